// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if
// Bundles the fetch unit's external channels:
//   imem_req_*   : fetch request (valid/ready), word-aligned address
//   imem_rsp_*   : in-order instruction response, no backpressure
//   redirect_*   : branch/jump redirect from execute
//   id_*         : instruction handoff to decode (valid/ready)
//   misalign_err : one-cycle pulse for a redirect target with nonzero [1:0]
// Modport master is the fetch unit; slave is its environment.
interface pc_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        misalign_err;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output id_valid, id_pc, id_instr, id_pc_plus4,
        input  id_ready,
        output misalign_err
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  id_valid, id_pc, id_instr, id_pc_plus4,
        output id_ready,
        input  misalign_err
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Fetch-stage front end: owns the architectural PC, issues one word fetch at
// a time to instruction memory, buffers responses in a small queue feeding
// decode, and flushes everything on a branch/jump redirect.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : pc_fetch_unit_if.master (imem request/response, redirect,
//          decode handoff, misalign_err)
// Parameters:
//   RESET_VECTOR : PC loaded on reset
//   QDEPTH       : response queue depth, 2 or 4
//
// state   | meaning
// S_REQ   | no request outstanding; request issued when queue has room
// S_WAIT  | one request outstanding; its response is pushed to the queue
// S_FLUSH | redirect hit an outstanding request; its response is dropped
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          QDEPTH       = 2
) (
    input logic             clk,
    input logic             rst,
    pc_fetch_unit_if.master bus
);
    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam int            CW      = $clog2(QDEPTH + 1);
    localparam int            PW      = $clog2(QDEPTH);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(QDEPTH);

    logic [1:0]    state;
    logic [31:0]   pc_q;
    logic [31:0]   req_addr_q;
    logic          outstanding;
    logic          misalign_q;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];

    logic [CW:0]   occ;
    logic          req_hs;
    logic          push;
    logic          pop;
    logic [31:0]   head_pc;

    // Queue entries plus the in-flight request must never exceed the queue
    // depth, so a response always has a slot waiting for it.
    assign occ = {1'b0, count} + {{CW{1'b0}}, outstanding};

    assign bus.imem_req_valid = !rst && (state == S_REQ) && (occ < DEPTH_C);
    assign bus.imem_req_addr  = pc_q;
    assign req_hs             = bus.imem_req_valid && bus.imem_req_ready;

    // A response arriving with a redirect belongs to the old path: drop it.
    assign push = (state == S_WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;
    assign pop  = bus.id_valid && bus.id_ready;

    // Storage is not reset, so head outputs are gated by id_valid to read 0
    // whenever the queue is empty (including out of reset).
    assign head_pc          = q_pc[rd_ptr];
    assign bus.id_valid     = (count != '0);
    assign bus.id_pc        = bus.id_valid ? head_pc         : 32'd0;
    assign bus.id_instr     = bus.id_valid ? q_instr[rd_ptr] : 32'd0;
    assign bus.id_pc_plus4  = bus.id_valid ? head_pc + 32'd4 : 32'd0;
    assign bus.misalign_err = misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_REQ;
            pc_q        <= RESET_VECTOR;
            req_addr_q  <= RESET_VECTOR;
            outstanding <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
            case (state)
                S_REQ: begin
                    if (req_hs) begin
                        req_addr_q  <= pc_q;
                        outstanding <= 1'b1;
                        pc_q        <= pc_q + 32'd4;
                        state       <= bus.redirect_valid ? S_FLUSH : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response in the redirect cycle settles the debt, so
                    // going to S_FLUSH there would wait forever.
                    if (bus.imem_rsp_valid) begin
                        outstanding <= 1'b0;
                        state       <= S_REQ;
                    end else if (bus.redirect_valid) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (bus.imem_rsp_valid) begin
                        outstanding <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                default: begin
                    outstanding <= 1'b0;
                    state       <= S_REQ;
                end
            endcase
            if (bus.redirect_valid) begin
                pc_q <= {bus.redirect_pc[31:2], 2'b00};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (bus.redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= req_addr_q;
            q_instr[wr_ptr] <= bus.imem_rsp_data;
        end
    end
endmodule
